uart_tx: RTL

UART_TX -- requirements
Module: UART_tx

---
 rtl/uart_tx.sv | 84 ++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// TX is a flop computed from next-state values, so it leads the internal state by no clock.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  typedef enum logic {IDLE, TRANSMITTING} state_t;

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  state_t      state, state_nxt;
  logic [8:0]  shft, shft_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [11:0] baud_cnt, baud_cnt_nxt;
  logic        tx_done_nxt;
  logic        tx_nxt;
  logic        accept;
  logic        shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shft     <= 9'h1FF;
      bit_cnt  <= 4'd0;
      baud_cnt <= 12'd0;
      tx_done  <= 1'b0;
      TX       <= 1'b1;
    end else begin
      state    <= state_nxt;
      shft     <= shft_nxt;
      bit_cnt  <= bit_cnt_nxt;
      baud_cnt <= baud_cnt_nxt;
      tx_done  <= tx_done_nxt;
      TX       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shft_nxt     = shft;
    bit_cnt_nxt  = bit_cnt;
    baud_cnt_nxt = baud_cnt;
    tx_done_nxt  = tx_done;
    accept       = (state == IDLE) && trmt;
    shift        = (state == TRANSMITTING) && (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = TRANSMITTING;
          shft_nxt     = {tx_data, 1'b0};
          bit_cnt_nxt  = 4'd0;
          baud_cnt_nxt = 12'd0;
          tx_done_nxt  = 1'b0;
        end
      end
      TRANSMITTING: begin
        if (shift) begin
          baud_cnt_nxt = 12'd0;
          shft_nxt     = {1'b1, shft[8:1]};
          bit_cnt_nxt  = bit_cnt + 4'd1;
          // Tenth shift closes the stop bit; requests seen until now were ignored.
          if (bit_cnt == 4'd9) begin
            state_nxt   = IDLE;
            tx_done_nxt = 1'b1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 12'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    tx_nxt = (state_nxt == TRANSMITTING) ? shft_nxt[0] : 1'b1;
  end

endmodule
